arith_pipe_unit: RTL and testbench

//  Parametrised successor to the fixed 4-bit registered adder/multiplier pair: one

---
 rtl/arith_pipe_unit.sv | 92 +++++++++
 tb/tb_arith_pipe_unit.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_pipe_unit.sv
// Pipelined ADD/SUB/MUL unit with valid/ready handshakes on both sides.
// Result is formed in stage 0; later stages only carry it towards the output.
module arith_pipe_unit #(
    parameter int WIDTH = 4,
    parameter int LAT   = 2,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [1:0]           out_op,
    output logic                 out_err,
    output logic [CNTW-1:0]      txn_count
);
    localparam int RW = 2 * WIDTH;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    logic [LAT-1:0]          vld_q;
    logic [LAT-1:0]          err_q;
    logic [LAT-1:0][1:0]     op_q;
    logic [LAT-1:0][RW-1:0]  res_q;

    logic          advance;
    logic          accept;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] res_d;
    logic          err_d;

    // The whole pipe moves as one; an empty output slot never blocks it.
    assign advance  = !vld_q[LAT-1] || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    assign a_ext = {{WIDTH{1'b0}}, in_a};
    assign b_ext = {{WIDTH{1'b0}}, in_b};

    // Subtracting zero-extended operands yields the sign-extended difference.
    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (in_op)
            OP_ADD:  res_d = a_ext + b_ext;
            OP_SUB:  res_d = a_ext - b_ext;
            OP_MUL:  res_d = a_ext * b_ext;
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else if (advance) begin
            vld_q[0] <= accept;
            err_q[0] <= err_d;
            op_q[0]  <= in_op;
            res_q[0] <= res_d;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                op_q[i]  <= op_q[i-1];
                res_q[i] <= res_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (out_valid && out_ready) begin
            txn_count <= txn_count + 1'b1;
        end
    end

    assign out_valid  = vld_q[LAT-1];
    assign out_err    = err_q[LAT-1];
    assign out_op     = op_q[LAT-1];
    assign out_result = res_q[LAT-1];

endmodule

// File: tb/tb_arith_pipe_unit.sv
// Scoreboard bench for arith_pipe_unit: a 4-bit/LAT=2/CNTW=4 instance
// for directed cases and an 8-bit/LAT=4 instance for a random stream.
module tb_arith_pipe_unit;

    typedef struct {
        logic [15:0] res;
        logic [1:0]  op;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 4-bit instance
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [1:0] a_in_op = '0;
    logic [3:0] a_in_a = '0;
    logic [3:0] a_in_b = '0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b1;
    logic [7:0] a_out_result;
    logic [1:0] a_out_op;
    logic       a_out_err;
    logic [3:0] a_txn;

    // 8-bit instance
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [1:0]  b_in_op = '0;
    logic [7:0]  b_in_a = '0;
    logic [7:0]  b_in_b = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_out_result;
    logic [1:0]  b_out_op;
    logic        b_out_err;
    logic [15:0] b_txn;

    arith_pipe_unit #(.WIDTH(4), .LAT(2), .CNTW(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_op(a_in_op), .in_a(a_in_a), .in_b(a_in_b),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_result(a_out_result), .out_op(a_out_op),
        .out_err(a_out_err), .txn_count(a_txn)
    );

    arith_pipe_unit #(.WIDTH(8), .LAT(4), .CNTW(16)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_op(b_in_op), .in_a(b_in_a), .in_b(b_in_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_op(b_out_op),
        .out_err(b_out_err), .txn_count(b_txn)
    );

    exp_t q4[$];
    exp_t q8[$];
    int   pref4[16384];
    int   pref8[16384];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Reference arithmetic on plain integers, wrapped to 2*w bits.
    function automatic logic [15:0] model(input int w, input logic [1:0] op,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
        int r;
        logic [31:0] m;
        case (op)
            2'd0:    r = int'(x) + int'(y);
            2'd1:    r = int'(x) - int'(y);
            2'd2:    r = int'(x) * int'(y);
            default: r = 0;
        endcase
        m = 32'(r) & ((32'd1 << (2 * w)) - 32'd1);
        return m[15:0];
    endfunction

    task automatic send4(input logic [1:0] op, input logic [3:0] x,
                         input logic [3:0] y);
        exp_t e;
        int n;
        n = 0;
        a_in_valid = 1'b1;
        a_in_op = op;
        a_in_a = x;
        a_in_b = y;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: in_ready stuck at 0");
        end else begin
            e.res = model(4, op, {4'd0, x}, {4'd0, y});
            e.op = op;
            e.err = (op == 2'b11);
            e.acc = cyc;
            q4.push_back(e);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send8(input logic [1:0] op, input logic [7:0] x,
                         input logic [7:0] y);
        exp_t e;
        int n;
        n = 0;
        b_in_valid = 1'b1;
        b_in_op = op;
        b_in_a = x;
        b_in_b = y;
        @(negedge clk);
        while (!b_in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) begin
            checks++;
            errors++;
            $display("FAIL b_accept_timeout: in_ready stuck at 0");
        end else begin
            e.res = model(8, op, x, y);
            e.op = op;
            e.err = (op == 2'b11);
            e.acc = cyc;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (q4.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("a_drain_left", q4.size(), 0);
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (q8.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b_drain_left", q8.size(), 0);
    endtask

    // Monitor for the 4-bit instance
    logic [3:0] cnt4 = '0;
    logic       hold4 = 1'b0;
    logic [7:0] hres4;
    logic [1:0] hop4;
    logic       herr4;

    always @(negedge clk) begin
        exp_t e;
        logic stall;
        int lat;
        if (cyc >= 16383) begin
            checks++;
            errors++;
            $display("FAIL a_cycle_budget: cycle %0d", cyc);
            $fatal(1);
        end
        if (rst) begin
            cnt4 = '0;
            hold4 = 1'b0;
            pref4[cyc] = pref4[cyc-1];
        end else begin
            chk("a_valid_known", 32'($isunknown(a_out_valid)), 0);
            stall = a_out_valid && !a_out_ready;
            chk("a_in_ready", a_in_ready, !stall);
            chk("a_txn_count", a_txn, cnt4);
            if (hold4) begin
                chk("a_hold_valid", a_out_valid, 1);
                chk("a_hold_result", a_out_result, hres4);
                chk("a_hold_op", a_out_op, hop4);
                chk("a_hold_err", a_out_err, herr4);
            end
            if (a_out_valid && a_out_ready) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_spurious: result %0h with empty queue",
                             a_out_result);
                end else begin
                    e = q4.pop_front();
                    lat = cyc - e.acc - (pref4[cyc-1] - pref4[e.acc]);
                    chk("a_result", a_out_result, e.res[7:0]);
                    chk("a_op", a_out_op, e.op);
                    chk("a_err", a_out_err, e.err);
                    chk("a_latency", lat, 2);
                end
                cnt4 = cnt4 + 1'b1;
            end
            pref4[cyc] = pref4[cyc-1] + int'(stall);
            hold4 = stall;
            hres4 = a_out_result;
            hop4 = a_out_op;
            herr4 = a_out_err;
        end
    end

    // Monitor for the 8-bit instance
    logic [15:0] cnt8 = '0;
    logic        hold8 = 1'b0;
    logic [15:0] hres8;
    logic [1:0]  hop8;
    logic        herr8;

    always @(negedge clk) begin
        exp_t e;
        logic stall;
        int lat;
        if (rst) begin
            cnt8 = '0;
            hold8 = 1'b0;
            pref8[cyc] = pref8[cyc-1];
        end else begin
            chk("b_valid_known", 32'($isunknown(b_out_valid)), 0);
            stall = b_out_valid && !b_out_ready;
            chk("b_in_ready", b_in_ready, !stall);
            chk("b_txn_count", b_txn, cnt8);
            if (hold8) begin
                chk("b_hold_valid", b_out_valid, 1);
                chk("b_hold_result", b_out_result, hres8);
                chk("b_hold_op", b_out_op, hop8);
                chk("b_hold_err", b_out_err, herr8);
            end
            if (b_out_valid && b_out_ready) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_spurious: result %0h with empty queue",
                             b_out_result);
                end else begin
                    e = q8.pop_front();
                    lat = cyc - e.acc - (pref8[cyc-1] - pref8[e.acc]);
                    chk("b_result", b_out_result, e.res);
                    chk("b_op", b_out_op, e.op);
                    chk("b_err", b_out_err, e.err);
                    chk("b_latency", lat, 4);
                end
                cnt8 = cnt8 + 1'b1;
            end
            pref8[cyc] = pref8[cyc-1] + int'(stall);
            hold8 = stall;
            hres8 = b_out_result;
            hop8 = b_out_op;
            herr8 = b_out_err;
        end
    end

    bit done8 = 1'b0;

    initial begin
        logic [1:0] op;
        logic [3:0] x4;
        logic [3:0] y4;
        logic [7:0] x8;
        logic [7:0] y8;
        int idle;

        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("a_ready_after_reset", a_in_ready, 1);
        chk("b_ready_after_reset", b_in_ready, 1);

        // Asynchronous reset with transactions in flight
        send4(2'b00, 4'd1, 4'd2);
        send4(2'b10, 4'd3, 4'd4);
        send4(2'b01, 4'd9, 4'd2);
        #2 rst = 1'b1;
        #1;
        chk("a_rst_valid", a_out_valid, 0);
        chk("a_rst_result", a_out_result, 0);
        chk("a_rst_txn", a_txn, 0);
        chk("b_rst_valid", b_out_valid, 0);
        chk("b_rst_txn", b_txn, 0);
        q4.delete();
        q8.delete();
        @(negedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("a_ready_post_release", a_in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("a_nothing_after_reset", a_out_valid, 0);

        // Basic ops back-to-back
        send4(2'b00, 4'd15, 4'd15);
        send4(2'b01, 4'd3, 4'd5);
        send4(2'b10, 4'd15, 4'd15);
        drain4();

        // Five MULs under a 1,0,0 ready pattern
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    x4 = 4'($urandom_range(0, 15));
                    y4 = 4'($urandom_range(0, 15));
                    send4(2'b10, x4, y4);
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    a_out_ready = (i % 3 == 0);
                    @(posedge clk);
                    #1;
                end
                a_out_ready = 1'b1;
            end
        join
        drain4();

        // Illegal opcode followed by a legal one
        send4(2'b11, 4'd7, 4'd9);
        send4(2'b00, 4'd7, 4'd9);
        drain4();

        // Counter wrap on the 4-bit counter
        @(posedge clk);
        #1 rst = 1'b1;
        q4.delete();
        q8.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            op = 2'($urandom_range(0, 3));
            x4 = 4'($urandom_range(0, 15));
            y4 = 4'($urandom_range(0, 15));
            send4(op, x4, y4);
        end
        drain4();
        chk("a_txn_wrap", a_txn, 1);

        // Random stream on the 8-bit, LAT=4 instance
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    idle = $urandom_range(0, 3);
                    if (idle > 1) begin
                        repeat (idle - 1) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    op = 2'($urandom_range(0, 3));
                    x8 = 8'($urandom_range(0, 255));
                    y8 = 8'($urandom_range(0, 255));
                    send8(op, x8, y8);
                end
                done8 = 1'b1;
            end
            begin
                while (!done8) begin
                    b_out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                b_out_ready = 1'b1;
            end
        join
        drain8();
        chk("b_txn_total", b_txn, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
